// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-driven ALU command sequencer.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_B     = 3'd1,
        GET_OP    = 3'd2,
        EXEC      = 3'd3,
        SEND_RES  = 3'd4,
        WAIT_RES  = 3'd5,
        SEND_STAT = 3'd6,
        WAIT_STAT = 3'd7
    } state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_SRA = 6'h03;

    localparam int unsigned STATUS_INVALID_BIT = 7;
    localparam int unsigned STATUS_CARRY_BIT   = 1;
    localparam int unsigned STATUS_ZERO_BIT    = 0;
    localparam logic [7:0]  STATUS_INVALID     = 8'h80;

    // The two high bits of the opcode byte are reserved and must be zero.
    function automatic logic is_valid_op(input logic [7:0] op_byte);
        if (op_byte[7:6] != 2'b00) begin
            return 1'b0;
        end
        case (op_byte[5:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear.
module inter_byte_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects A/B/opcode bytes from UART RX, runs the external ALU, and returns
// result and status bytes through UART TX.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done_tick,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_zero,
    input  logic               i_alu_carry,
    output logic               o_busy,
    output logic               o_err
);

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic               valid_q, valid_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic [NB_DATA-1:0] status_q, status_d;
    logic               tx_start_q, tx_start_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               rx_accept;
    logic               timer_en;
    logic               timer_expired;

    assign timer_en = (state_q == GET_B) || (state_q == GET_OP);

    inter_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (rx_accept || err_d),
        .i_en     (timer_en),
        .o_expired(timer_expired)
    );

    // Outputs are registered, so tx_start/tx_data are computed one state early.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        valid_d    = valid_q;
        result_d   = result_q;
        status_d   = status_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
        rx_accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rx_done_tick) begin
                    alu_a_d   = i_rx_data;
                    rx_accept = 1'b1;
                    state_d   = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done_tick) begin
                    alu_b_d   = i_rx_data;
                    rx_accept = 1'b1;
                    state_d   = GET_OP;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_OP: begin
                if (i_rx_done_tick) begin
                    alu_op_d  = i_rx_data[NB_OP-1:0];
                    valid_d   = is_valid_op(8'(i_rx_data));
                    rx_accept = 1'b1;
                    state_d   = EXEC;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (valid_q) begin
                    result_d                   = i_alu_result;
                    status_d                   = '0;
                    status_d[STATUS_CARRY_BIT] = i_alu_carry;
                    status_d[STATUS_ZERO_BIT]  = i_alu_zero;
                end else begin
                    result_d = '0;
                    status_d = NB_DATA'(STATUS_INVALID);
                end
                tx_start_d = 1'b1;
                tx_data_d  = result_d;
                state_d    = SEND_RES;
            end
            SEND_RES: begin
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (i_tx_done_tick) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = status_q;
                    state_d    = SEND_STAT;
                end
            end
            SEND_STAT: begin
                state_d = WAIT_STAT;
            end
            WAIT_STAT: begin
                if (i_tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            status_q   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            status_q   <= status_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;

endmodule
